lowbit: RTL and testbench
=========================

Name: lowbit

Overview:
- Trailing-zero counter / lowest-set-bit locator for a 32-bit word.
- Outputs the bit index (0..31) of the least-significant 1 in numin, or 32 when numin is zero.
- Output is registered: one clock of latency.
- Utility block for the datapath, e.g. a custom ALU or extension instruction that returns the lowbit position.

Parameters:
- None. Widths are fixed: 32-bit input, 6-bit output.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- numin  input  32  operand word; sampled every rising clk edge.
- numout  output  6  index of the lowest set bit of the numin sampled at the previous edge; 6'd32 if that numin was 0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset:
  - While reset=1, numout = 6'd0 immediately, without waiting for clk.
  - numout holds 0 until the first rising edge after reset deasserts.
- Function, combinational core: enc = smallest i in 0..31 with numin[i]=1; enc = 6'd32 when numin == 32'h0.
  - Equivalent definition: enc = log2(numin & (~numin + 1)) for non-zero numin.
- Latency:
  - At each rising clk edge with reset=0, numout <= enc(numin).
  - Exactly 1 cycle from input to output.
  - No handshake; a new operand is accepted every cycle.
- Width rules:
  - numout[5] = 1 only for the zero-input case.
  - For non-zero input, numout[5] = 0 and numout[4:0] is the index.
- Boundaries:
  - numin = 32'h80000000 -> 31.
  - numin = 32'h00000001 -> 0.
  - numin = 0 -> 32.
  - Upper bits never affect the result once a lower bit is set (e.g. 32'hFFFFFFFF -> 0).
- Output is a pure function of the previous cycle's numin. There is no other state: no sticky or accumulated behaviour.
- X/undefined bits on numin need not be handled specially.
- Reset asserted mid-stream forces numout to 0 asynchronously. On release, the next edge loads enc of the then-present numin.

Decomposition:
- Shared package lowbit_pkg:
  - DATA_W = 32
  - IDX_W = 6
  - ZERO_IDX = 6'd32
- Sub-module lowbit_enc: purely combinational, numin[31:0] -> enc[5:0].
  - Implemented as a log-depth tree: 2-bit leaf encoders merged pairwise up to 32 bits, each node outputting {all_zero, index}.
  - Top level lowbit instantiates lowbit_enc and holds only the output register and async reset.

Test Plan:
- Reset: assert reset with numin = 32'h5 -> numout = 0 asynchronously, before any clk edge. Deassert, one edge -> numout = 0 (index of bit0).
- Small values, one per cycle: 1, 2, 3, 4, 5, 6 -> numout one cycle later = 0, 1, 0, 2, 0, 1.
- Dense words: FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC, FFFFFFFB, FFFFFFFA -> 0, 1, 0, 2, 0, 1.
- Extremes:
  - 32'h0 -> 32.
  - 32'h80000000 -> 31.
  - 32'h00010000 -> 16.
  - 32'hA0000000 -> 29.
- Latency and back-to-back: change numin every cycle -> numout always equals the golden model of the previous cycle's numin, with no bubbles.
- Exhaustive one-hot sweep: 1<<i for i = 0..31 -> numout = i. Plus 1000 random words checked against a golden trailing-zero model.

Source files
------------

// File: rtl/lowbit_pkg.sv
// Shared widths and constants for the lowest-set-bit locator.
package lowbit_pkg;
  localparam int DATA_W = 32;
  localparam int IDX_W  = 6;
  localparam logic [IDX_W-1:0] ZERO_IDX = 6'd32;
endpackage

// File: rtl/lowbit_enc.sv
// Combinational trailing-zero encoder: log-depth tree of {all_zero, index} nodes.
// 2-bit leaves are merged pairwise; the lower half wins unless it is all zero.
module lowbit_enc
  import lowbit_pkg::*;
(
  input  logic [DATA_W-1:0] numin,
  output logic [IDX_W-1:0]  enc
);

  logic [15:0] z1;
  logic [15:0] i1;
  logic [7:0]  z2;
  logic [1:0]  i2 [8];
  logic [3:0]  z3;
  logic [2:0]  i3 [4];
  logic [1:0]  z4;
  logic [3:0]  i4 [2];
  logic        z5;
  logic [4:0]  i5;

  for (genvar n = 0; n < 16; n++) begin : g_leaf
    assign z1[n] = ~(numin[2*n] | numin[2*n+1]);
    assign i1[n] = ~numin[2*n];
  end

  for (genvar n = 0; n < 8; n++) begin : g_l2
    assign z2[n] = z1[2*n] & z1[2*n+1];
    assign i2[n] = z1[2*n] ? {1'b1, i1[2*n+1]} : {1'b0, i1[2*n]};
  end

  for (genvar n = 0; n < 4; n++) begin : g_l3
    assign z3[n] = z2[2*n] & z2[2*n+1];
    assign i3[n] = z2[2*n] ? {1'b1, i2[2*n+1]} : {1'b0, i2[2*n]};
  end

  for (genvar n = 0; n < 2; n++) begin : g_l4
    assign z4[n] = z3[2*n] & z3[2*n+1];
    assign i4[n] = z3[2*n] ? {1'b1, i3[2*n+1]} : {1'b0, i3[2*n]};
  end

  assign z5 = z4[0] & z4[1];
  assign i5 = z4[0] ? {1'b1, i4[1]} : {1'b0, i4[0]};

  assign enc = z5 ? ZERO_IDX : {1'b0, i5};

endmodule

// File: rtl/lowbit.sv
// Registered lowest-set-bit locator: numout = index of lowest 1 in last-cycle numin, 32 if zero.
// One cycle latency, new operand every cycle, asynchronous active-high reset clears the output.
module lowbit
  import lowbit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] numin,
  output logic [IDX_W-1:0]  numout
);

  logic [IDX_W-1:0] numout_d;
  logic [IDX_W-1:0] numout_q;

  lowbit_enc u_enc (
    .numin (numin),
    .enc   (numout_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) numout_q <= '0;
    else       numout_q <= numout_d;
  end

  assign numout = numout_q;

endmodule

// File: tb/tb_lowbit.sv
// Directed and random checks of the registered trailing-zero counter.
module tb_lowbit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] numin = 32'h0;
  logic [5:0]  numout;

  int checks = 0;
  int errors = 0;

  lowbit dut (
    .clk    (clk),
    .reset  (reset),
    .numin  (numin),
    .numout (numout)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] golden(input logic [31:0] v);
    logic [5:0] r;
    r = 6'd32;
    for (int i = 31; i >= 0; i--)
      if (v[i]) r = 6'(i);
    return r;
  endfunction

  task automatic check(input logic [5:0] exp, input string tag);
    checks++;
    assert (numout === exp) else begin
      errors++;
      $error("FAIL %s: numout=%0d expected=%0d", tag, numout, exp);
    end
  endtask

  // Drive one operand, take one edge, check the registered result.
  task automatic cyc(input logic [31:0] v, input logic [5:0] exp, input string tag);
    numin = v;
    @(posedge clk);
    #1;
    check(exp, tag);
  endtask

  logic [31:0] small_v [6] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
  logic [31:0] dense_v [6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD,
                               32'hFFFFFFFC, 32'hFFFFFFFB, 32'hFFFFFFFA};
  logic [5:0]  pat_e   [6] = '{6'd0, 6'd1, 6'd0, 6'd2, 6'd0, 6'd1};
  logic [31:0] rv;

  initial begin
    // Asynchronous reset before any clock edge.
    numin = 32'h5;
    #2 reset = 1'b1;
    #1 check(6'd0, "reset_async");
    @(posedge clk); #1 check(6'd0, "reset_hold");
    @(negedge clk); reset = 1'b0;
    #1 check(6'd0, "reset_release_no_edge");
    @(posedge clk); #1 check(6'd0, "after_reset_bit0");

    for (int k = 0; k < 6; k++) cyc(small_v[k], pat_e[k], "small");
    for (int k = 0; k < 6; k++) cyc(dense_v[k], pat_e[k], "dense");

    cyc(32'h00000000, 6'd32, "zero");
    cyc(32'h80000000, 6'd31, "msb");
    cyc(32'h00010000, 6'd16, "bit16");
    cyc(32'hA0000000, 6'd29, "a0000000");
    cyc(32'h00000001, 6'd0,  "lsb");
    cyc(32'h00000000, 6'd32, "zero_again");
    cyc(32'h40000000, 6'd30, "bit30");

    // Mid-stream reset forces zero with no edge; release loads then-present operand.
    cyc(32'h80000000, 6'd31, "pre_reset");
    @(negedge clk); reset = 1'b1;
    #1 check(6'd0, "reset_midstream");
    numin = 32'h00000010;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1 check(6'd4, "post_reset_load");

    for (int i = 0; i < 32; i++) cyc(32'h1 << i, 6'(i), "onehot");

    for (int k = 0; k < 1000; k++) begin
      rv = $urandom;
      if (k % 3 == 0) rv = rv << $urandom_range(0, 31);
      if (k % 97 == 0) rv = 32'h0;
      cyc(rv, golden(rv), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
